// File: rtl/sram_ctrl_32to16.sv
// 32-bit word requests to a 16-bit asynchronous SRAM bus: each word is split into
// a low and a high halfword access with programmable wait states per phase.
module sram_ctrl_32to16 #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 18
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W:0]   i_addr,
  input  logic [3:0]        i_bmask,
  input  logic [31:0]       i_wdata,
  output logic              o_ready,
  output logic              o_ack,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  typedef enum logic [2:0] {IDLE, LO, LO_REC, HI, HI_REC, DONE} state_t;

  // Every bus pin comes straight from this register, so strobes are glitch-free.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              ce_n;
    logic              oe_n;
    logic              we_n;
    logic              lb_n;
    logic              ub_n;
    logic              drive;
    logic [15:0]       dq;
  } bus_t;

  localparam logic [2:0] W_LAST = 3'(WAIT_CYCLES);

  state_t            state;
  logic [2:0]        cnt;
  bus_t              bus_q;
  logic              we_q;
  logic [ADDR_W-2:0] waddr_q;
  logic [3:0]        mask_q;
  logic [31:0]       wdata_q;
  logic [15:0]       rlo_q;
  logic              dq_drive;
  logic              phase_end;
  logic              unused_addr_lsb;

  assign phase_end       = (cnt == W_LAST);
  assign unused_addr_lsb = ^i_addr[1:0];

  function automatic bus_t phase_bus(input logic [ADDR_W-2:0] wa, input logic hi,
                                     input logic we, input logic [3:0] m,
                                     input logic [31:0] d);
    bus_t b;
    b.addr  = {wa, hi};
    b.ce_n  = 1'b0;
    b.oe_n  = we;
    b.we_n  = ~we;
    b.lb_n  = we ? ~(hi ? m[2] : m[0]) : 1'b0;
    b.ub_n  = we ? ~(hi ? m[3] : m[1]) : 1'b0;
    b.drive = we;
    b.dq    = hi ? d[31:16] : d[15:0];
    return b;
  endfunction

  // Address is kept so the bus does not toggle needlessly between accesses.
  function automatic bus_t idle_bus(input bus_t cur);
    bus_t b;
    b       = cur;
    b.ce_n  = 1'b1;
    b.oe_n  = 1'b1;
    b.we_n  = 1'b1;
    b.lb_n  = 1'b1;
    b.ub_n  = 1'b1;
    b.drive = 1'b0;
    return b;
  endfunction

  // NOTE: state and outputs update with non-blocking assignments so every branch
  // reads the pre-edge values; the async reset drops the DQ driver immediately.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bus_q   <= idle_bus('0);
      o_ready <= 1'b1;
      o_ack   <= 1'b0;
      o_rdata <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      rlo_q   <= '0;
    end else begin
      o_ack <= 1'b0;
      case (state)
        IDLE: if (i_req) begin
          o_ready <= 1'b0;
          we_q    <= i_we;
          waddr_q <= i_addr[ADDR_W:2];
          mask_q  <= i_bmask;
          wdata_q <= i_wdata;
          if (!i_we || |i_bmask[1:0]) begin
            state <= LO;
            bus_q <= phase_bus(i_addr[ADDR_W:2], 1'b0, i_we, i_bmask, i_wdata);
          end else if (|i_bmask[3:2]) begin
            state <= HI;
            bus_q <= phase_bus(i_addr[ADDR_W:2], 1'b1, i_we, i_bmask, i_wdata);
          end else begin
            state <= DONE;
            o_ack <= 1'b1;
          end
        end
        LO: if (!phase_end) begin
          cnt <= cnt + 3'd1;
        end else begin
          cnt <= '0;
          if (we_q) begin
            state      <= LO_REC;
            bus_q.we_n <= 1'b1;
          end else begin
            rlo_q <= io_sram_dq;
            state <= HI;
            bus_q <= phase_bus(waddr_q, 1'b1, 1'b0, mask_q, wdata_q);
          end
        end
        LO_REC: if (|mask_q[3:2]) begin
          state <= HI;
          bus_q <= phase_bus(waddr_q, 1'b1, 1'b1, mask_q, wdata_q);
        end else begin
          state <= DONE;
          o_ack <= 1'b1;
          bus_q <= idle_bus(bus_q);
        end
        HI: if (!phase_end) begin
          cnt <= cnt + 3'd1;
        end else begin
          cnt <= '0;
          if (we_q) begin
            state      <= HI_REC;
            bus_q.we_n <= 1'b1;
          end else begin
            o_rdata <= {io_sram_dq, rlo_q};
            state   <= DONE;
            o_ack   <= 1'b1;
            bus_q   <= idle_bus(bus_q);
          end
        end
        HI_REC: begin
          state <= DONE;
          o_ack <= 1'b1;
          bus_q <= idle_bus(bus_q);
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dq_drive    = bus_q.drive;
  assign io_sram_dq  = dq_drive ? bus_q.dq : 16'bz;
  assign o_sram_addr = bus_q.addr;
  assign o_sram_ce_n = bus_q.ce_n;
  assign o_sram_oe_n = bus_q.oe_n;
  assign o_sram_we_n = bus_q.we_n;
  assign o_sram_lb_n = bus_q.lb_n;
  assign o_sram_ub_n = bus_q.ub_n;

endmodule

// File: tb/tb_sram_ctrl_32to16.sv
// Bench for sram_ctrl_32to16: a 16-bit SRAM model on the bus plus a scoreboard of
// expected latency, strobe counts and read data per request.
module tb_sram_ctrl_32to16;
  localparam int W  = 1;
  localparam int AW = 18;

  typedef struct {
    logic        is_read;
    logic [31:0] rdata;
    int          lat;
    int          ce_low;
    int          oe_low;
    int          we_low;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW:0]   addr = '0;
  logic [3:0]    bmask = '0;
  logic [31:0]   wdata = '0;
  logic          ready, ack;
  logic [31:0]   rdata;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;

  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];
  exp_t        sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_ops = 0;
  int          ack_total = 0;
  int          obs_ce, obs_oe, obs_we, obs_drive_bad;
  logic [AW-1:0] last_we_addr;
  logic [1:0]    last_we_lanes;

  always #5 clk = ~clk;

  sram_ctrl_32to16 #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_we(we), .i_addr(addr),
    .i_bmask(bmask), .i_wdata(wdata), .o_ready(ready), .o_ack(ack),
    .o_rdata(rdata), .o_sram_addr(sram_addr), .io_sram_dq(sram_dq),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  // SRAM model: drives DQ on reads, stores enabled lanes on each clock with WE low.
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : 16'bz;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
    end
  end

  always @(negedge clk) if (ack) ack_total <= ack_total + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic w, input logic [AW:0] a, input logic [3:0] m,
                       input logic [31:0] d, input bit pulse_busy);
    exp_t e;
    int   n, waits, nh;
    bit   got_ack;
    logic [9:0] idx_lo, idx_hi, idx;
    idx_lo = {a[10:2], 1'b0};
    idx_hi = {a[10:2], 1'b1};
    if (!w) begin
      e.is_read = 1'b1;
      e.rdata   = {ref_mem[idx_hi], ref_mem[idx_lo]};
      e.lat     = 2 * (W + 1) + 1;
      e.ce_low  = 2 * (W + 1);
      e.oe_low  = 2 * (W + 1);
      e.we_low  = 0;
    end else begin
      nh        = int'(|m[1:0]) + int'(|m[3:2]);
      e.is_read = 1'b0;
      e.rdata   = '0;
      e.lat     = (nh == 0) ? 1 : nh * (W + 2) + 1;
      e.ce_low  = nh * (W + 2);
      e.oe_low  = 0;
      e.we_low  = nh * (W + 1);
      for (int b = 0; b < 4; b++)
        if (m[b]) begin
          idx = (b < 2) ? idx_lo : idx_hi;
          ref_mem[idx][8*(b%2) +: 8] = d[8*b +: 8];
        end
    end
    sb.push_back(e);

    @(negedge clk);
    waits = 0;
    while (!ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("ready_before_req", 32'(ready), 32'd1);
    req = 1'b1; we = w; addr = a; bmask = m; wdata = d;
    @(posedge clk);
    #1 req = 1'b0;
    n_ops++;

    n = 0; got_ack = 1'b0;
    obs_ce = 0; obs_oe = 0; obs_we = 0; obs_drive_bad = 0;
    while (!got_ack && n < 100) begin
      @(negedge clk);
      n++;
      if (pulse_busy && n == 2) begin
        req = 1'b1; we = 1'b1; bmask = 4'hF; wdata = 32'h1234_5678;
      end
      if (pulse_busy && n == 3) req = 1'b0;
      if (!ce_n) obs_ce++;
      if (!oe_n) obs_oe++;
      if (!we_n) begin
        obs_we++;
        last_we_addr  = sram_addr;
        last_we_lanes = {lb_n, ub_n};
      end
      if (dut.dq_drive && (!w || !oe_n)) obs_drive_bad++;
      if (ack) got_ack = 1'b1;
    end

    e = sb.pop_front();
    check("ack_latency", 32'(n), 32'(e.lat));
    check("ce_low_cycles", 32'(obs_ce), 32'(e.ce_low));
    check("oe_low_cycles", 32'(obs_oe), 32'(e.oe_low));
    check("we_low_cycles", 32'(obs_we), 32'(e.we_low));
    check("dq_contention", 32'(obs_drive_bad), 32'd0);
    if (e.is_read) check("rdata", rdata, e.rdata);
    @(negedge clk);
    check("ack_one_cycle", 32'(ack), 32'd0);
    check("dq_released", 32'(dut.dq_drive), 32'd0);
    if (e.is_read) check("rdata_held", rdata, e.rdata);
    if (w) begin
      check("mem_lo", 32'(mem[idx_lo]), 32'(ref_mem[idx_lo]));
      check("mem_hi", 32'(mem[idx_hi]), 32'(ref_mem[idx_hi]));
    end
  endtask

  task automatic abort_write();
    int acks_before;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 19'h400; bmask = 4'hF; wdata = 32'h5566_7788;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("abort_in_lo_we_n", 32'(we_n), 32'd0);
    acks_before = ack_total;
    #1 rstn = 1'b0;
    #1;
    check("abort_we_n", 32'(we_n), 32'd1);
    check("abort_ce_n", 32'(ce_n), 32'd1);
    check("abort_dq_z", 32'(dut.dq_drive), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    repeat (3) @(negedge clk);
    check("abort_no_ack", 32'(ack_total), 32'(acks_before));
    rstn = 1'b1;
    check("abort_mem_lo", 32'(mem[10'h200]), 32'(ref_mem[10'h200]));
    check("abort_mem_hi", 32'(mem[10'h201]), 32'(ref_mem[10'h201]));
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    rstn = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_strobes", {27'd0, ce_n, oe_n, we_n, lb_n, ub_n}, 32'h1F);
    check("post_rst_dq_z", 32'(dut.dq_drive), 32'd0);
    check("post_rst_rdata", rdata, 32'd0);
    check("post_rst_addr", 32'(sram_addr), 32'd0);
    check("post_rst_no_ack", 32'(ack_total), 32'd0);

    do_op(1'b1, 19'h400, 4'hF, 32'hDEAD_BEEF, 1'b0);
    do_op(1'b0, 19'h400, 4'h0, 32'h0, 1'b1);
    do_op(1'b1, 19'h400, 4'b0100, 32'h00AA_0000, 1'b0);
    check("hi_only_addr", 32'(last_we_addr), 32'h201);
    check("hi_only_lanes", 32'(last_we_lanes), 32'b01);
    do_op(1'b0, 19'h400, 4'h0, 32'h0, 1'b0);
    do_op(1'b1, 19'h400, 4'b0000, 32'hFFFF_FFFF, 1'b0);
    do_op(1'b1, 19'h408, 4'b0011, 32'h1122_3344, 1'b0);
    do_op(1'b1, 19'h40C, 4'b0010, 32'hCAFE_F00D, 1'b0);
    check("lo_ub_only_lanes", 32'(last_we_lanes), 32'b10);
    do_op(1'b0, 19'h408, 4'h0, 32'h0, 1'b0);
    do_op(1'b0, 19'h40C, 4'h0, 32'h0, 1'b0);

    abort_write();
    check("post_abort_rdata", rdata, 32'd0);
    do_op(1'b0, 19'h400, 4'h0, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    check("ack_count", 32'(ack_total), 32'(n_ops));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end
endmodule
